// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and frame constants shared by the UART transmitter and receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT} uart_state_e;
  localparam int CLOCK_PER_BIT_DEF = 13021;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous input, reset to RST_VAL
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk) sync_q <= rst ? {2{RST_VAL}} : {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling with stop-bit check.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BIT = CLOCK_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 RX_busy,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 frame_err
);
  localparam int CW = $clog2(CLOCK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'((CLOCK_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLOCK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, busy_q, busy_d, rx_s;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif
  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d_i(RX_in), .q_o(rx_s));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: begin
        cnt_d = (cnt_q == HALF) ? '0 : cnt_q + CW'(1);
        if (cnt_q == HALF) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          shift_d[idx_q] = rx_s;
          idx_d = idx_q + IW'(1);
`ifdef UART_RX_PARITY_EN
          if (idx_q == LAST_IDX) state_d = PARITY;
`else
          if (idx_q == LAST_IDX) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          par_d = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = rx_s ? IDLE : WAIT;
          ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d  = ^{shift_q, par_q};
          valid_d = rx_s && !perr_d;
`else
          valid_d = rx_s;
`endif
          data_d  = valid_d ? shift_q : data_q;
        end
      end
      WAIT: state_d = rx_s ? IDLE : WAIT;
      default: begin
        state_d = IDLE;
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign RX_busy    = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames from a bit-level BFM, scored against expected bytes and latency
module tb_uart_rx;
  typedef struct {logic [7:0] d; int c;} rec_t;
  typedef struct {int sel; logic [7:0] d; int c;} exp_t;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] d1, d2;
  logic v1, v2, b1, b2, fe1, fe2;
`ifdef UART_RX_PARITY_EN
  logic pe1, pe2;
  int pe1_cnt = 0;
`endif
  int cyc = 0, fe1_cnt = 0, both_cnt = 0, passed = 0, total = 0;
  rec_t q1[$], q2[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLOCK_PER_BIT(16)) dut1 (.clk(clk), .rst(rst), .RX_in(rx1), .data_out(d1),
    .data_valid(v1), .RX_busy(b1),
`ifdef UART_RX_PARITY_EN
    .parity_err(pe1),
`endif
    .frame_err(fe1));
  uart_rx #(.CLOCK_PER_BIT(100)) dut2 (.clk(clk), .rst(rst), .RX_in(rx2), .data_out(d2),
    .data_valid(v2), .RX_busy(b2),
`ifdef UART_RX_PARITY_EN
    .parity_err(pe2),
`endif
    .frame_err(fe2));

  always @(negedge clk) begin
    if (v1) q1.push_back('{d1, cyc});
    if (v2) q2.push_back('{d2, cyc});
    if (fe1) fe1_cnt++;
    if ((v1 && fe1) || (v2 && fe2)) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (pe1) pe1_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int lat(input int sel);
    int cpb = sel ? 100 : 16;
    return 2 + (cpb - 1) / 2 + (9 + PB) * cpb + 1;
  endfunction

  task automatic drv(input int sel, input logic v);
    if (sel == 0) rx1 = v;
    else rx2 = v;
  endtask

  // bit-level frame: start, 8 data LSB first, optional even parity, stop (or a held-low break)
  task automatic send(input int sel, input logic [7:0] b, input int per, input int stop_low, input bit flip);
    logic bits[$];
    bits = {1'b0};
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (PB == 1) bits.push_back(^b ^ flip);
    if (stop_low == 0 && !flip) exp_q.push_back('{sel, b, cyc + 1});
    foreach (bits[i]) begin
      drv(sel, bits[i]);
      repeat (per) @(negedge clk);
    end
    drv(sel, stop_low == 0);
    repeat (stop_low == 0 ? per : stop_low * per) @(negedge clk);
  endtask

  task automatic drain();
    exp_t e;
    rec_t r;
    int n, sz;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      sz = (e.sel == 0) ? q1.size() : q2.size();
      while (sz == 0 && n < 4000) begin
        @(negedge clk);
        n++;
        sz = (e.sel == 0) ? q1.size() : q2.size();
      end
      chk("rx_arrived", sz > 0, 1);
      if (sz > 0) begin
        if (e.sel == 0) r = q1.pop_front();
        else r = q2.pop_front();
        chk("rx_data", r.d, e.d);
        chk("rx_latency", r.c - e.c, lat(e.sel));
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    repeat (3) @(negedge clk);
    chk("rst_data", d1, 8'h00);
    chk("rst_valid", v1, 0);
    chk("rst_busy", b1, 0);
    chk("rst_ferr", fe1, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy", b1, 0);
    // back-to-back frames with no idle gap
    send(0, 8'hA5, 16, 0, 0);
    send(0, 8'h3C, 16, 0, 0);
    drain();
    chk("b2b_ferr", fe1_cnt, 0);
    chk("b2b_hold", d1, 8'h3C);
    // short low glitch is rejected
    rx1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy_hi", b1, 1);
    rx1 = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_lo", b1, 0);
    chk("glitch_no_valid", q1.size(), 0);
    chk("glitch_no_ferr", fe1_cnt, 0);
    // stop bit held low: one frame error, data held, busy until line recovers
    send(0, 8'h55, 16, 3, 0);
    chk("break_ferr", fe1_cnt, 1);
    chk("break_busy", b1, 1);
    chk("break_hold", d1, 8'h3C);
    chk("break_no_valid", q1.size(), 0);
    rx1 = 1'b1;
    repeat (32) @(negedge clk);
    chk("break_busy_lo", b1, 0);
    send(0, 8'h81, 16, 0, 0);
    drain();
    // reset during data bit 4 of 8'hFF
    rx1 = 1'b0;
    repeat (16) @(negedge clk);
    rx1 = 1'b1;
    repeat (4 * 16 + 8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_data", d1, 8'h00);
    chk("midrst_valid", v1, 0);
    chk("midrst_busy", b1, 0);
    chk("midrst_ferr", fe1, 0);
    rst = 1'b0;
    repeat (6 * 16) @(negedge clk);
    chk("midrst_no_valid", q1.size(), 0);
    send(0, 8'h00, 16, 0, 0);
    drain();
    // random bytes with random idle gaps
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      send(0, rb, 16, 0, 0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    drain();
    // +/-2% baud skew on the slower instance
    send(1, 8'h7E, 98, 0, 0);
    drain();
    rb = 8'($urandom);
    send(1, rb, 102, 0, 0);
    drain();
`ifdef UART_RX_PARITY_EN
    send(0, 8'hA5, 16, 0, 0);
    drain();
    send(0, 8'hA5, 16, 0, 1);
    repeat (40) @(negedge clk);
    chk("par_err_cnt", pe1_cnt, 1);
    chk("par_no_valid", q1.size(), 0);
`endif
    repeat (20) @(negedge clk);
    chk("extra_valid1", q1.size(), 0);
    chk("extra_valid2", q2.size(), 0);
    chk("valid_ferr_overlap", both_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
